// File: rtl/sgd_pkg.sv
// Shared constants, FSM state type and packed-slice helper for the SGD MAC array.
package sgd_pkg;

  localparam int unsigned LENGTH       = 16;
  localparam int unsigned FRAC         = 8;
  localparam int unsigned MAX_FEATURES = 15;
  localparam int unsigned NUM_LANES    = 4;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // LSB of slice k in a word packed with slice 0 in the MSB position.
  function automatic int unsigned slice_lo(int unsigned k, int unsigned len,
                                           int unsigned nfeat);
    return len * (nfeat - k);
  endfunction

endpackage

// File: rtl/sgd_bw_mult.sv
// Combinational signed Baugh-Wooley multiplier; keeps product bits [FRAC+LENGTH-1:FRAC].
module sgd_bw_mult #(
  parameter int unsigned LENGTH = 16,
  parameter int unsigned FRAC   = 8
) (
  input  logic [LENGTH-1:0] a,
  input  logic [LENGTH-1:0] b,
  output logic [LENGTH-1:0] p
);

  localparam int unsigned PW = 2 * LENGTH;
  localparam logic [PW-1:0] ONE     = PW'(1);
  localparam logic [PW-1:0] BW_CORR = (ONE << LENGTH) | (ONE << (PW - 1));

  logic [PW-1:0] full;
  logic [PW-1:0] row;
  logic [PW-FRAC-LENGTH-1:0] unused_hi;
  logic [FRAC:0] unused_lo;

  // Cross terms against a sign bit are inverted; BW_CORR restores the two's-complement sum.
  always_comb begin
    full = BW_CORR;
    row  = '0;
    for (int unsigned i = 0; i < LENGTH; i++) begin
      row = '0;
      for (int unsigned j = 0; j < LENGTH; j++) begin
        if ((i == LENGTH - 1) != (j == LENGTH - 1))
          row[i+j] = ~(a[i] & b[j]);
        else
          row[i+j] = a[i] & b[j];
      end
      full = full + row;
    end
  end

  assign {unused_hi, p} = full[PW-1:FRAC];
  assign unused_lo      = {full[FRAC-1:0], 1'b0};

endmodule

// File: rtl/sgd_mac_array.sv
// Four-lane fixed-point MAC: dot product (W0 + sum Wi*Xi) or gradient (Xi*err) over 4 cycles.
module sgd_mac_array
  import sgd_pkg::*;
#(
  parameter int unsigned LENGTH       = sgd_pkg::LENGTH,
  parameter int unsigned FRAC         = sgd_pkg::FRAC,
  parameter int unsigned MAX_FEATURES = sgd_pkg::MAX_FEATURES,
  parameter int unsigned NUM_LANES    = sgd_pkg::NUM_LANES,
  parameter int unsigned DATA_WIDTH   = LENGTH * (MAX_FEATURES + 1)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  start,
  input  logic                  mode,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic [DATA_WIDTH-1:0] weights,
  input  logic [LENGTH-1:0]     err,
  output logic                  busy,
  output logic                  done,
  output logic [LENGTH-1:0]     y_cap,
  output logic [DATA_WIDTH-1:0] grad
);

  localparam int unsigned STEPS = (MAX_FEATURES + NUM_LANES) / NUM_LANES;
  localparam int unsigned CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  state_t state, state_next;
  logic [CW-1:0]         cyc;
  logic [DATA_WIDTH-1:0] data_q, weights_q;
  logic [LENGTH-1:0]     err_q, acc, acc_base, acc_sum;
  logic                  mode_q, accept;
  logic [LENGTH-1:0]     x_sel [NUM_LANES];
  logic [LENGTH-1:0]     w_sel [NUM_LANES];
  logic [LENGTH-1:0]     b_sel [NUM_LANES];
  logic [LENGTH-1:0]     prod  [NUM_LANES];

  function automatic int unsigned lane_feat(int unsigned lane, logic [CW-1:0] c);
    return 1 + lane * STEPS + 32'(c);
  endfunction

  assign accept = (state == IDLE) && start && !busy;

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (accept) state_next = RUN;
      RUN:     if (cyc == CW'(STEPS - 1)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Out-of-range lane slots (lane 4 on the last cycle) feed zero into the multiplier.
  always_comb begin
    for (int unsigned l = 0; l < NUM_LANES; l++) begin
      x_sel[l] = '0;
      w_sel[l] = '0;
      if (lane_feat(l, cyc) <= MAX_FEATURES) begin
        x_sel[l] = data_q[slice_lo(lane_feat(l, cyc), LENGTH, MAX_FEATURES) +: LENGTH];
        w_sel[l] = weights_q[slice_lo(lane_feat(l, cyc), LENGTH, MAX_FEATURES) +: LENGTH];
      end
      b_sel[l] = mode_q ? err_q : w_sel[l];
    end
  end

  always_comb begin
    acc_base = (cyc == '0) ? weights_q[slice_lo(0, LENGTH, MAX_FEATURES) +: LENGTH] : acc;
    acc_sum  = acc_base;
    for (int unsigned l = 0; l < NUM_LANES; l++)
      acc_sum = acc_sum + prod[l];
  end

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    sgd_bw_mult #(.LENGTH(LENGTH), .FRAC(FRAC)) u_mult (
      .a(x_sel[l]),
      .b(b_sel[l]),
      .p(prod[l])
    );
  end

  // done is registered off DONE, so it lands one edge after the state and busy spans it.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      cyc       <= '0;
      data_q    <= '0;
      weights_q <= '0;
      err_q     <= '0;
      mode_q    <= 1'b0;
      acc       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      y_cap     <= '0;
      grad      <= '0;
    end else begin
      state <= state_next;
      busy  <= (state_next != IDLE) || (state == DONE);
      done  <= (state == DONE);
      if (accept) begin
        data_q    <= data;
        weights_q <= weights;
        err_q     <= err;
        mode_q    <= mode;
        cyc       <= '0;
      end
      if (state == RUN) begin
        acc <= acc_sum;
        cyc <= cyc + 1'b1;
        if (!mode_q) begin
          if (cyc == CW'(STEPS - 1)) y_cap <= acc_sum;
        end else begin
          grad[slice_lo(0, LENGTH, MAX_FEATURES) +: LENGTH] <= err_q;
          for (int unsigned l = 0; l < NUM_LANES; l++)
            if (lane_feat(l, cyc) <= MAX_FEATURES)
              grad[slice_lo(lane_feat(l, cyc), LENGTH, MAX_FEATURES) +: LENGTH] <= prod[l];
        end
      end
    end
  end

endmodule

// File: tb/tb_sgd_mac_array.sv
// Scoreboard bench for sgd_mac_array: directed plan cases plus random ops vs. an arithmetic model.
module tb_sgd_mac_array;
  import sgd_pkg::*;

  localparam int unsigned DW = LENGTH * (MAX_FEATURES + 1);

  logic CLK = 1'b0;
  logic RST, start, mode;
  logic [DW-1:0] data, weights;
  logic [LENGTH-1:0] err;
  logic busy, done;
  logic [LENGTH-1:0] y_cap;
  logic [DW-1:0] grad;

  sgd_mac_array #(
    .LENGTH(LENGTH), .FRAC(FRAC), .MAX_FEATURES(MAX_FEATURES),
    .NUM_LANES(NUM_LANES), .DATA_WIDTH(DW)
  ) dut (
    .CLK(CLK), .RST(RST), .start(start), .mode(mode), .data(data),
    .weights(weights), .err(err), .busy(busy), .done(done),
    .y_cap(y_cap), .grad(grad)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [LENGTH-1:0] y;
    logic [DW-1:0]     g;
    int unsigned       due;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int total = 0;
  int bad = 0;
  int unsigned ncnt = 0;
  logic [LENGTH-1:0] model_y = '0;
  logic [DW-1:0]     model_g = '0;

  function automatic logic [LENGTH-1:0] slc(logic [DW-1:0] v, int k);
    return v[DW-1-LENGTH*k -: LENGTH];
  endfunction

  function automatic logic [DW-1:0] put(logic [DW-1:0] v, int k, logic [LENGTH-1:0] s);
    logic [DW-1:0] r;
    r = v;
    r[DW-1-LENGTH*k -: LENGTH] = s;
    return r;
  endfunction

  // Fixed-point product: exact integer product, arithmetic shift (floor), keep low LENGTH bits.
  function automatic logic [LENGTH-1:0] fx_mul(logic [LENGTH-1:0] a, logic [LENGTH-1:0] b);
    longint pr;
    pr = longint'($signed(a)) * longint'($signed(b));
    pr = pr >>> FRAC;
    return pr[LENGTH-1:0];
  endfunction

  function automatic logic [DW-1:0] rnd_word();
    logic [DW-1:0] r;
    r = '0;
    for (int k = 0; k <= MAX_FEATURES; k++) r = put(r, k, LENGTH'($urandom));
    return r;
  endfunction

  task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    ncnt++;
    if (done) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done=1 expected no pending op (cycle %0d)", ncnt);
      end else begin
        mon_e = q.pop_front();
        check("latency", DW'(ncnt), DW'(mon_e.due));
        check("y_cap", DW'(y_cap), DW'(mon_e.y));
        check("grad", grad, mon_e.g);
      end
    end
  end

  task automatic wait_drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 40) begin
      @(negedge CLK); #1;
      n++;
    end
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL timeout: got %0d pending ops expected 0", q.size());
      q.delete();
    end
    repeat (2) begin @(negedge CLK); #1; end
  endtask

  task automatic issue(input logic [DW-1:0] d, input logic [DW-1:0] w,
                       input logic [LENGTH-1:0] e, input logic m, input bit poke);
    exp_t x;
    logic [LENGTH-1:0] acc;
    if (!m) begin
      acc = slc(w, 0);
      for (int k = 1; k <= MAX_FEATURES; k++) acc = acc + fx_mul(slc(w, k), slc(d, k));
      model_y = acc;
    end else begin
      model_g = put(model_g, 0, e);
      for (int k = 1; k <= MAX_FEATURES; k++) model_g = put(model_g, k, fx_mul(slc(d, k), e));
    end
    @(negedge CLK); #1;
    data = d; weights = w; err = e; mode = m; start = 1'b1;
    x.y = model_y; x.g = model_g; x.due = ncnt + 6;
    q.push_back(x);
    @(negedge CLK); #1;
    start = 1'b0;
    data = rnd_word(); weights = rnd_word(); err = LENGTH'($urandom); mode = ~m;
    if (poke) begin
      @(negedge CLK); #1; start = 1'b1;
      @(negedge CLK); #1; start = 1'b0;
    end
    wait_drain();
  endtask

  task automatic fill(output logic [DW-1:0] d, output logic [DW-1:0] w,
                      input logic [LENGTH-1:0] dv, input logic [LENGTH-1:0] wv);
    d = '0; w = '0;
    for (int k = 0; k <= MAX_FEATURES; k++) begin
      d = put(d, k, (k == 0) ? '0 : dv);
      w = put(w, k, wv);
    end
  endtask

  logic [DW-1:0] d, w;
  bit seen_done;

  initial begin
    RST = 1'b1; start = 1'b0; mode = 1'b0; data = '0; weights = '0; err = '0;
    repeat (3) begin @(negedge CLK); #1; end
    RST = 1'b0;
    check("rst_busy", DW'(busy), '0);
    check("rst_done", DW'(done), '0);
    check("rst_y_cap", DW'(y_cap), '0);
    check("rst_grad", grad, '0);

    fill(d, w, 16'h0200, 16'h0100);
    issue(d, w, 16'h0000, 1'b0, 1'b0);

    d = '0;
    for (int k = 1; k <= MAX_FEATURES; k++) d = put(d, k, LENGTH'(k * 16'h0100));
    issue(d, rnd_word(), 16'h0080, 1'b1, 1'b0);

    d = put('0, 1, 16'h0300); w = put('0, 1, 16'hFF00);
    issue(d, w, 16'h1111, 1'b0, 1'b0);
    d = put('0, 1, 16'h0001); w = put('0, 1, 16'hFFFF);
    issue(d, w, 16'h2222, 1'b0, 1'b0);

    d = put(put('0, 1, 16'h7F00), 0, 16'h1234); w = put('0, 1, 16'h0200);
    issue(d, w, 16'h0000, 1'b0, 1'b1);

    for (int i = 0; i < 40; i++)
      issue(rnd_word(), rnd_word(), LENGTH'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0));

    // Abort mid-run: no expectation is queued, so any later done is flagged by the monitor.
    @(negedge CLK); #1;
    data = rnd_word(); weights = rnd_word(); err = 16'h0040; mode = 1'b0; start = 1'b1;
    @(negedge CLK); #1; start = 1'b0;
    @(negedge CLK); #1; RST = 1'b1;
    @(negedge CLK); #1; RST = 1'b0;
    model_y = '0; model_g = '0;
    check("abort_busy", DW'(busy), '0);
    check("abort_y_cap", DW'(y_cap), '0);
    check("abort_grad", grad, '0);
    seen_done = 1'b0;
    repeat (8) begin @(negedge CLK); #1; seen_done |= done; end
    check("abort_no_done", DW'(seen_done), '0);

    fill(d, w, 16'h0100, 16'hFE80);
    issue(d, w, 16'h0000, 1'b0, 1'b0);

    check("queue_empty", DW'(q.size()), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got time limit expected completion");
    $fatal(1, "bench time limit");
  end

endmodule

// File: doc/sgd_mac_array.md
Name: sgd_mac_array

Overview:
- Four-lane signed fixed-point multiply datapath for the SGD regression engine. It time-multiplexes 15 features over 4 multiplier lanes across 4 cycles.
- Each lane feeds its multiplier through a 4:1 feature mux and a 2:1 operand mux that selects either the weight or the error.
- Two modes:
  - dot-product mode: y_cap = W0 + Σ Wi·Xi.
  - gradient mode: Gi = Xi·err for the weight update.

Parameters:
- LENGTH, 16, word width (two's complement).
- FRAC, 8, fractional bits (Q8.8 by default).
- MAX_FEATURES, 15, feature count; fixed at 15 for the 4-lane × 4-cycle schedule.
- NUM_LANES, 4, multiplier lanes.
- DATA_WIDTH, LENGTH*(MAX_FEATURES+1), width of the packed word.

Ports:
- CLK input 1: clock, rising edge.
- RST input 1: synchronous, active-high reset.
- start input 1: one-cycle request, accepted only in IDLE.
- mode input 1: 0 = dot product (weight operand), 1 = gradient (error operand); sampled with start.
- data input DATA_WIDTH: slice 0 (MSB) is y and is unused here; slice k (k=1..15) is feature Xk at bits [DATA_WIDTH-1-LENGTH*k -: LENGTH].
- weights input DATA_WIDTH: slice k is Wk at the same packing, W0 in the MSB slice.
- err input LENGTH: error operand for gradient mode.
- busy output 1: high while computing.
- done output 1: one-cycle pulse when results are valid.
- y_cap output LENGTH: dot-product result.
- grad output DATA_WIDTH: slice 0 = err; slice k = Xk·err (k=1..15).

Behaviour:
- Interface: one clock CLK; reset RST is synchronous and active-high.
- Reset values: state IDLE; busy, done, y_cap, grad, cycle counter and all captured operand registers are 0.
- Operand capture: on start in IDLE, data, weights, err and mode are registered. Later changes on the inputs have no effect until the next start.
- States and transitions:
  - IDLE → RUN on start.
  - RUN holds for 4 cycles, cycle_count 0..3, then → DONE.
  - DONE lasts one cycle with done=1, then → IDLE.
- busy is 1 in RUN and DONE. start is ignored while busy.
- Latency: start at edge E0; done is high in the cycle after edge E5 (5 cycles start-to-done).
- Lane feature mux, for cycle c:
  - lane1 uses X(1+c), covering X1–X4.
  - lane2 uses X(5+c), covering X5–X8.
  - lane3 uses X(9+c), covering X9–X12.
  - lane4 uses X(13+c) for c=0..2 and constant 0 for c=3.
- Weight mux uses the same mapping on W1..W15; lane4 gets 0 at c=3.
- Operand mux: mode 0 → weight-mux output; mode 1 → captured err.
- Multiplier: signed LENGTH×LENGTH → 2·LENGTH full product, Baugh-Wooley structure. The result is bits [FRAC+LENGTH-1:FRAC], truncated toward −∞ with wrap on overflow (no saturation).
- Dot mode: acc ← W0 at c=0 start. Every RUN cycle, acc ← acc + P1+P2+P3+P4, modulo 2^LENGTH. y_cap ← acc at the end of c=3. grad is unchanged.
- Gradient mode: at cycle c, grad slice (lane*4−3+c) ← lane product for each lane with a valid feature; grad slice 0 ← err. y_cap is unchanged.
- RST mid-operation: RST at any edge returns to IDLE and clears all outputs; no done pulse follows.
- start coincident with RST: RST wins.

Decomposition:
- Shared package sgd_pkg holds:
  - LENGTH, FRAC, MAX_FEATURES, NUM_LANES;
  - the state enum {IDLE, RUN, DONE};
  - a slice-index helper function.
- One natural sub-module, sgd_bw_mult: combinational signed Baugh-Wooley multiplier with fixed-point truncation, instantiated 4×.
- The 4:1 and 2:1 muxes stay inline.

Test Plan:
1. Dot, positive: W0=0x0100, W1..15=0x0100, X1..15=0x0200, start → done after 5 cycles, y_cap=0x1F00 (31.0), grad unchanged 0.
2. Gradient: err=0x0080, Xk=k·0x0100, mode=1 → grad slice k = k·0x0080 (slice 15 = 0x0780), slice 0 = 0x0080.
3. Signed/truncation: W1=0xFF00, X1=0x0300, all else 0, W0=0 → y_cap=0xFD00. X1=0x0001, W1=0xFFFF → y_cap=0xFFFF (floor).
4. Overflow wrap: W1=0x0200, X1=0x7F00, others 0 → y_cap=0xFE00. Lane4 slot c=3 contributes 0 even if the MSB slice holds nonzero y.
5. Control: start while busy ignored (single done pulse). Inputs changed after start do not alter the result. RST during RUN → busy=0, done never pulses, y_cap=0.
